bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Common-bus arbiter for the 8-processor MESI cache system.
- Grants bus mastership to one processor-side cache controller at a time (Com_Bus_Req_proc_N / Com_Bus_Gnt_proc_N).
- While a processor owns the bus, it grants one responder slot to one snoop-side controller (4 snoopers) or to the memory snoop agent (Mem_snoop_req / Mem_snoop_gnt).
- Sits between the cache_wrapper instances and the memory controller on the common bus.

Parameters:
- None. Port counts are fixed: 8 processor requesters, 4 snoop requesters, 1 memory snoop requester.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- Com_Bus_Req_proc_0..7  input  1 each  processor-side bus request, held high for the whole transaction
- Com_Bus_Req_snoop_0..3  input  1 each  snoop-side responder request
- Com_Bus_Gnt_proc_0..7  output  1 each  processor bus grant, one-hot or zero
- Com_Bus_Gnt_snoop_0..3  output  1 each  snoop responder grant, one-hot or zero
- Mem_snoop_req  input  1  memory agent responder request
- Mem_snoop_gnt  output  1  memory agent responder grant

Behaviour:
- Reset:
  - rst_n low clears all grants to 0 immediately (asynchronous).
  - Proc round-robin pointer resets to 0; snoop pointer resets to 0.
- All grants are registered. Combinational request-to-grant paths are forbidden.
- Proc arbitration, states IDLE / OWNED:
  - IDLE: on a rising edge with any proc request high, grant the first requester found searching upward from the pointer (mod 8). Go to OWNED. Pointer becomes winner+1 (mod 8).
  - Grant latency is 1 cycle: request sampled at edge k, grant high after edge k.
  - OWNED: grant held while the owner's request stays high. Other requests are ignored and nothing is preempted.
  - When the owner's request is sampled low, the grant drops at that edge and the state returns to IDLE. The next grant comes no earlier than the following edge, giving one mandatory turnaround cycle.
  - Simultaneous requests are resolved only by the round-robin order.
- Snoop/memory arbitration:
  - Active only while the proc state is OWNED. In IDLE, all snoop grants and Mem_snoop_gnt are 0 and requests are ignored.
  - No responder grant held: on an edge, grant the snoop requester found first upward from the snoop pointer (mod 4). The pointer advances to winner+1.
  - If no snoop request is high and Mem_snoop_req is high, assert Mem_snoop_gnt. Caches always beat memory in the same cycle.
  - A responder grant is held while its request stays high, with no preemption; it drops on the edge where its request is sampled low.
  - A new responder grant may be issued on the same edge the previous one drops.
  - If the proc owner releases the bus, all responder grants clear at that same edge, whatever their requests.
- Invariants, checked every cycle:
  - At most one Com_Bus_Gnt_proc is high.
  - At most one of {Com_Bus_Gnt_snoop_0..3, Mem_snoop_gnt} is high.
  - No responder grant is high without a proc grant.
  - Outputs are never X/Z after reset.
- Reset mid-transaction: all grants drop asynchronously and both pointers return to 0.

Decomposition:
- Shared package:
  - NUM_PROC=8, NUM_SNOOP=4
  - arb_state_t enum {IDLE, OWNED}
- One sub-module, rr_pick: parameterised-width combinational round-robin selector (req vector, pointer) -> one-hot winner plus valid. Instantiated twice, 8-wide and 4-wide.
- Top block holds the state and pointer registers and the memory fallback.

Test Plan:
- Reset: hold rst_n=0 with all requests high -> all grants 0. Release -> proc0 granted 1 cycle later.
- Single request: Req_proc_3 high at edge k -> Gnt_proc_3 high after edge k, held for 10 cycles. Req low -> grant low at the next edge.
- Round-robin fairness: Req_proc_0 and Req_proc_5 both held, each pulsing low 1 cycle after 4 cycles of grant -> grants alternate 0,5,0,5 with one idle cycle between grants.
- Responder gating: Req_snoop_2 and Mem_snoop_req high, no proc owner -> no responder grants. Proc1 granted -> Gnt_snoop_2 one cycle later and Mem_snoop_gnt=0. Snoop_2 drops -> Mem_snoop_gnt asserted on that same edge.
- Owner release: Gnt_proc_4 and Gnt_snoop_1 both active, Req_proc_4 drops -> both grants clear at the same edge even though Req_snoop_1 is still high.
- Async reset mid-operation: assert rst_n=0 between edges while grants are active -> grants drop immediately. After release, arbitration restarts from proc0 / snoop0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the common-bus arbiter.
//   NUM_PROC / NUM_SNOOP : fixed requester counts
//   arb_state_t          : processor-side ownership state
//   proc_idx / snoop_idx : one-hot to binary index helpers
package bus_arbiter_pkg;

    localparam int unsigned NUM_PROC    = 8;
    localparam int unsigned NUM_SNOOP   = 4;
    localparam int unsigned PROC_PTR_W  = 3;
    localparam int unsigned SNOOP_PTR_W = 2;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_t;

    function automatic logic [PROC_PTR_W-1:0] proc_idx(input logic [NUM_PROC-1:0] oh);
        logic [PROC_PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_PROC; i++) begin
            if (oh[i]) idx = PROC_PTR_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [SNOOP_PTR_W-1:0] snoop_idx(input logic [NUM_SNOOP-1:0] oh);
        logic [SNOOP_PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_SNOOP; i++) begin
            if (oh[i]) idx = SNOOP_PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : index searched first; search wraps upward modulo WIDTH
//   gnt   : one-hot winner (zero when no request)
//   valid : at least one request present
module rr_pick #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [WIDTH-1:0] gnt,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            idx = PTR_W'((32'(ptr) + i) % WIDTH);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Common-bus arbiter for the 8-processor MESI system.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   Com_Bus_Req_proc_0..7 / Gnt   : processor bus ownership request / registered grant
//   Com_Bus_Req_snoop_0..3 / Gnt  : snoop responder request / registered grant
//   Mem_snoop_req / Mem_snoop_gnt : memory responder request / registered grant
// One processor owns the bus until it drops its request; while it does, one responder
// (cache snooper preferred over memory) is granted at a time.
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic Com_Bus_Req_proc_0,
    input  logic Com_Bus_Req_proc_1,
    input  logic Com_Bus_Req_proc_2,
    input  logic Com_Bus_Req_proc_3,
    input  logic Com_Bus_Req_proc_4,
    input  logic Com_Bus_Req_proc_5,
    input  logic Com_Bus_Req_proc_6,
    input  logic Com_Bus_Req_proc_7,
    input  logic Com_Bus_Req_snoop_0,
    input  logic Com_Bus_Req_snoop_1,
    input  logic Com_Bus_Req_snoop_2,
    input  logic Com_Bus_Req_snoop_3,
    input  logic Mem_snoop_req,
    output logic Com_Bus_Gnt_proc_0,
    output logic Com_Bus_Gnt_proc_1,
    output logic Com_Bus_Gnt_proc_2,
    output logic Com_Bus_Gnt_proc_3,
    output logic Com_Bus_Gnt_proc_4,
    output logic Com_Bus_Gnt_proc_5,
    output logic Com_Bus_Gnt_proc_6,
    output logic Com_Bus_Gnt_proc_7,
    output logic Com_Bus_Gnt_snoop_0,
    output logic Com_Bus_Gnt_snoop_1,
    output logic Com_Bus_Gnt_snoop_2,
    output logic Com_Bus_Gnt_snoop_3,
    output logic Mem_snoop_gnt
);

    logic [NUM_PROC-1:0]    proc_req;
    logic [NUM_SNOOP-1:0]   snoop_req;

    arb_state_t             state_q, state_d;
    logic [PROC_PTR_W-1:0]  proc_ptr_q, proc_ptr_d;
    logic [NUM_PROC-1:0]    proc_gnt_q, proc_gnt_d;
    logic [SNOOP_PTR_W-1:0] snoop_ptr_q, snoop_ptr_d;
    logic [NUM_SNOOP-1:0]   snoop_gnt_q, snoop_gnt_d;
    logic                   mem_gnt_q, mem_gnt_d;

    logic [NUM_PROC-1:0]    proc_pick;
    logic                   proc_pick_valid;
    logic [NUM_SNOOP-1:0]   snoop_pick;
    logic                   snoop_pick_valid;

    logic                   owner_keep;
    logic                   resp_keep;

    assign proc_req = {Com_Bus_Req_proc_7, Com_Bus_Req_proc_6, Com_Bus_Req_proc_5,
                       Com_Bus_Req_proc_4, Com_Bus_Req_proc_3, Com_Bus_Req_proc_2,
                       Com_Bus_Req_proc_1, Com_Bus_Req_proc_0};
    assign snoop_req = {Com_Bus_Req_snoop_3, Com_Bus_Req_snoop_2,
                        Com_Bus_Req_snoop_1, Com_Bus_Req_snoop_0};

    rr_pick #(
        .WIDTH (NUM_PROC)
    ) u_proc_pick (
        .req   (proc_req),
        .ptr   (proc_ptr_q),
        .gnt   (proc_pick),
        .valid (proc_pick_valid)
    );

    rr_pick #(
        .WIDTH (NUM_SNOOP)
    ) u_snoop_pick (
        .req   (snoop_req),
        .ptr   (snoop_ptr_q),
        .gnt   (snoop_pick),
        .valid (snoop_pick_valid)
    );

    // The current holder keeps its grant only while it is still requesting.
    assign owner_keep = |(proc_gnt_q & proc_req);
    assign resp_keep  = (|(snoop_gnt_q & snoop_req)) | (mem_gnt_q & Mem_snoop_req);

    always_comb begin
        state_d     = state_q;
        proc_ptr_d  = proc_ptr_q;
        proc_gnt_d  = proc_gnt_q;
        snoop_ptr_d = snoop_ptr_q;
        snoop_gnt_d = snoop_gnt_q;
        mem_gnt_d   = mem_gnt_q;

        unique case (state_q)
            IDLE: begin
                // Responders are never granted on the edge that hands out ownership.
                snoop_gnt_d = '0;
                mem_gnt_d   = 1'b0;
                if (proc_pick_valid) begin
                    state_d    = OWNED;
                    proc_gnt_d = proc_pick;
                    proc_ptr_d = proc_idx(proc_pick) + PROC_PTR_W'(1);
                end
            end
            OWNED: begin
                if (!owner_keep) begin
                    // Release also tears down any responder; IDLE gives the turnaround cycle.
                    state_d     = IDLE;
                    proc_gnt_d  = '0;
                    snoop_gnt_d = '0;
                    mem_gnt_d   = 1'b0;
                end else if (!resp_keep) begin
                    // Nothing held (or holder just dropped): re-arbitrate on this same edge.
                    if (snoop_pick_valid) begin
                        snoop_gnt_d = snoop_pick;
                        mem_gnt_d   = 1'b0;
                        snoop_ptr_d = snoop_idx(snoop_pick) + SNOOP_PTR_W'(1);
                    end else begin
                        snoop_gnt_d = '0;
                        mem_gnt_d   = Mem_snoop_req;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                proc_gnt_d  = '0;
                snoop_gnt_d = '0;
                mem_gnt_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            proc_ptr_q  <= '0;
            proc_gnt_q  <= '0;
            snoop_ptr_q <= '0;
            snoop_gnt_q <= '0;
            mem_gnt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            proc_ptr_q  <= proc_ptr_d;
            proc_gnt_q  <= proc_gnt_d;
            snoop_ptr_q <= snoop_ptr_d;
            snoop_gnt_q <= snoop_gnt_d;
            mem_gnt_q   <= mem_gnt_d;
        end
    end

    assign Com_Bus_Gnt_proc_0  = proc_gnt_q[0];
    assign Com_Bus_Gnt_proc_1  = proc_gnt_q[1];
    assign Com_Bus_Gnt_proc_2  = proc_gnt_q[2];
    assign Com_Bus_Gnt_proc_3  = proc_gnt_q[3];
    assign Com_Bus_Gnt_proc_4  = proc_gnt_q[4];
    assign Com_Bus_Gnt_proc_5  = proc_gnt_q[5];
    assign Com_Bus_Gnt_proc_6  = proc_gnt_q[6];
    assign Com_Bus_Gnt_proc_7  = proc_gnt_q[7];
    assign Com_Bus_Gnt_snoop_0 = snoop_gnt_q[0];
    assign Com_Bus_Gnt_snoop_1 = snoop_gnt_q[1];
    assign Com_Bus_Gnt_snoop_2 = snoop_gnt_q[2];
    assign Com_Bus_Gnt_snoop_3 = snoop_gnt_q[3];
    assign Mem_snoop_gnt       = mem_gnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter. Grant vector layout: {mem, snoop[3:0], proc[7:0]}.
module tb_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req_proc;
    logic [3:0]  req_snoop;
    logic        req_mem;
    logic [7:0]  gnt_proc;
    logic [3:0]  gnt_snoop;
    logic        gnt_mem;
    logic [12:0] gnt_vec;

    int tests;
    int failed;

    typedef struct {
        logic [12:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb_q[$];

    assign gnt_vec = {gnt_mem, gnt_snoop, gnt_proc};

    bus_arbiter u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .Com_Bus_Req_proc_0  (req_proc[0]),
        .Com_Bus_Req_proc_1  (req_proc[1]),
        .Com_Bus_Req_proc_2  (req_proc[2]),
        .Com_Bus_Req_proc_3  (req_proc[3]),
        .Com_Bus_Req_proc_4  (req_proc[4]),
        .Com_Bus_Req_proc_5  (req_proc[5]),
        .Com_Bus_Req_proc_6  (req_proc[6]),
        .Com_Bus_Req_proc_7  (req_proc[7]),
        .Com_Bus_Req_snoop_0 (req_snoop[0]),
        .Com_Bus_Req_snoop_1 (req_snoop[1]),
        .Com_Bus_Req_snoop_2 (req_snoop[2]),
        .Com_Bus_Req_snoop_3 (req_snoop[3]),
        .Mem_snoop_req       (req_mem),
        .Com_Bus_Gnt_proc_0  (gnt_proc[0]),
        .Com_Bus_Gnt_proc_1  (gnt_proc[1]),
        .Com_Bus_Gnt_proc_2  (gnt_proc[2]),
        .Com_Bus_Gnt_proc_3  (gnt_proc[3]),
        .Com_Bus_Gnt_proc_4  (gnt_proc[4]),
        .Com_Bus_Gnt_proc_5  (gnt_proc[5]),
        .Com_Bus_Gnt_proc_6  (gnt_proc[6]),
        .Com_Bus_Gnt_proc_7  (gnt_proc[7]),
        .Com_Bus_Gnt_snoop_0 (gnt_snoop[0]),
        .Com_Bus_Gnt_snoop_1 (gnt_snoop[1]),
        .Com_Bus_Gnt_snoop_2 (gnt_snoop[2]),
        .Com_Bus_Gnt_snoop_3 (gnt_snoop[3]),
        .Mem_snoop_gnt       (gnt_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected grant constants, hand-derived.
    localparam logic [12:0] NONE = 13'h0000;
    localparam logic [12:0] P0   = 13'h0001;
    localparam logic [12:0] P1   = 13'h0002;
    localparam logic [12:0] P3   = 13'h0008;
    localparam logic [12:0] P4   = 13'h0010;
    localparam logic [12:0] P5   = 13'h0020;
    localparam logic [12:0] P6   = 13'h0040;
    localparam logic [12:0] S0   = 13'h0100;
    localparam logic [12:0] S1   = 13'h0200;
    localparam logic [12:0] S2   = 13'h0400;
    localparam logic [12:0] S3   = 13'h0800;
    localparam logic [12:0] M    = 13'h1000;

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic ok);
        tests++;
        if (ok !== 1'b1) begin
            failed++;
            $display("FAIL %s: grants %h violate invariant (t=%0t)", name, gnt_vec, $time);
        end
    endtask

    // Drive one cycle of requests and queue the grants expected after the next edge.
    task automatic step(input string name, input logic [7:0] rp, input logic [3:0] rs,
                        input logic rm, input logic [12:0] exp);
        sb_item_t it;
        @(negedge clk);
        req_proc  = rp;
        req_snoop = rs;
        req_mem   = rm;
        it.exp    = exp;
        it.name   = name;
        sb_q.push_back(it);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_proc  = '0;
        req_snoop = '0;
        req_mem   = 1'b0;
        #2;
        check("rst_clear", gnt_vec, NONE);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: pop and compare one expectation per edge; invariants every cycle.
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1) begin
            sb_item_t it;
            check_bit("no_x", !$isunknown(gnt_vec));
            check_bit("proc_onehot", $onehot0(gnt_proc));
            check_bit("resp_onehot", $onehot0({gnt_snoop, gnt_mem}));
            check_bit("resp_needs_owner", !((|{gnt_snoop, gnt_mem}) && !(|gnt_proc)));
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                check(it.name, gnt_vec, it.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d expectations pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        tests     = 0;
        failed    = 0;
        rst_n     = 1'b1;
        req_proc  = '1;
        req_snoop = '1;
        req_mem   = 1'b1;
        #1;
        rst_n = 1'b0;

        // Reset held with every request high.
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", gnt_vec, NONE);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step("rst_rel_p0", 8'hFF, 4'hF, 1'b1, P0);
        step("rst_rel_s0", 8'hFF, 4'hF, 1'b1, P0 | S0);
        step("rst_rel_drop", 8'h00, 4'h0, 1'b0, NONE);

        // Single requester, held ten cycles.
        do_reset();
        for (int i = 0; i < 11; i++) step("single_p3", 8'h08, 4'h0, 1'b0, P3);
        step("single_drop", 8'h00, 4'h0, 1'b0, NONE);
        step("single_idle", 8'h00, 4'h0, 1'b0, NONE);

        // Fairness between proc0 and proc5.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) step("rr_p0", 8'h21, 4'h0, 1'b0, P0);
            step("rr_turn0", 8'h20, 4'h0, 1'b0, NONE);
            for (int i = 0; i < 4; i++) step("rr_p5", 8'h21, 4'h0, 1'b0, P5);
            step("rr_turn5", 8'h01, 4'h0, 1'b0, NONE);
        end
        step("rr_end", 8'h00, 4'h0, 1'b0, NONE);

        // Responder gating and memory fallback.
        do_reset();
        step("gate_idle", 8'h00, 4'h4, 1'b1, NONE);
        step("gate_idle", 8'h00, 4'h4, 1'b1, NONE);
        step("gate_own_p1", 8'h02, 4'h4, 1'b1, P1);
        step("gate_s2", 8'h02, 4'h4, 1'b1, P1 | S2);
        step("gate_s2_hold", 8'h02, 4'h4, 1'b1, P1 | S2);
        step("gate_mem", 8'h02, 4'h0, 1'b1, P1 | M);
        step("gate_mem_hold", 8'h02, 4'h0, 1'b1, P1 | M);
        step("gate_mem_drop", 8'h02, 4'h0, 1'b0, P1);
        step("gate_end", 8'h00, 4'h0, 1'b0, NONE);

        // Owner release clears the responder too.
        do_reset();
        step("rel_p4", 8'h10, 4'h2, 1'b0, P4);
        step("rel_s1", 8'h10, 4'h2, 1'b0, P4 | S1);
        step("rel_s1_hold", 8'h10, 4'h2, 1'b0, P4 | S1);
        step("rel_clear", 8'h00, 4'h2, 1'b0, NONE);
        step("rel_idle_ign", 8'h00, 4'h2, 1'b0, NONE);
        step("rel_end", 8'h00, 4'h0, 1'b0, NONE);

        // Pointers now proc=5, snoop=2; async reset mid-transaction must restore both to 0.
        step("mid_p6", 8'h41, 4'h9, 1'b0, P6);
        step("mid_s3", 8'h41, 4'h9, 1'b0, P6 | S3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_drop", gnt_vec, NONE);
        #1;
        rst_n = 1'b1;
        step("restart_p0", 8'h41, 4'h9, 1'b0, P0);
        step("restart_s0", 8'h41, 4'h9, 1'b0, P0 | S0);
        step("restart_end", 8'h00, 4'h0, 1'b0, NONE);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
